// File: rtl/pipe_csa_adder.sv
// Pipelined carry-select adder: one SLICE-bit slice resolved per stage, operands skewed in, results deskewed out.
// Define PIPE_CSA_SUB_EN to enable subtraction (sub=1 -> a - b, cout=1 means no borrow).

module csa_slice #(
    parameter int W = 64
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         ci_i,
    output logic [W-1:0] s_o,
    output logic         co_o
);
    logic [W:0] s0, s1;

    // Both carry hypotheses are formed in parallel; the incoming carry only drives the mux.
    assign s0 = {1'b0, a_i} + {1'b0, b_i};
    assign s1 = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, 1'b1};
    assign {co_o, s_o} = ci_i ? s1 : s0;
endmodule

module pipe_csa_adder #(
    parameter int WIDTH = 256,
    parameter int SLICE = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int STAGES = WIDTH / SLICE;

    if (WIDTH % SLICE != 0) begin : g_cfg_err
        $error("WIDTH must be an integer multiple of SLICE");
    end

    logic              adv;
    logic [STAGES:1]   vld_q;
    logic [WIDTH-1:0]  b_in;
    logic              c_in;

`ifdef PIPE_CSA_SUB_EN
    assign b_in = sub ? ~b : b;
    assign c_in = sub ? 1'b1 : cin;
`else
    logic unused_sub;
    assign unused_sub = sub;
    assign b_in       = b;
    assign c_in       = cin;
`endif

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else if (adv) begin
            vld_q[1] <= in_valid;
            for (int k = 2; k <= STAGES; k++) vld_q[k] <= vld_q[k-1];
        end
    end

    // Level k+1 word: slices 0..k hold results, slices above still hold operand a.
    for (genvar k = 0; k < STAGES; k++) begin : g_lvl
        localparam int BW = WIDTH - k * SLICE;

        logic [WIDTH-1:0] aw, w_d, w_q;
        logic [BW-1:0]    bw;
        logic [SLICE-1:0] s_s;
        logic             ci, co, cy_q;

        if (k == 0) begin : g_src
            assign aw = a;
            assign bw = b_in;
            assign ci = c_in;
        end else begin : g_src
            assign aw = g_lvl[k-1].w_q;
            assign bw = g_lvl[k-1].g_b.b_q;
            assign ci = g_lvl[k-1].cy_q;
        end

        csa_slice #(.W(SLICE)) u_slice (
            .a_i  (aw[k*SLICE +: SLICE]),
            .b_i  (bw[SLICE-1:0]),
            .ci_i (ci),
            .s_o  (s_s),
            .co_o (co)
        );

        always_comb begin
            w_d                     = aw;
            w_d[k*SLICE +: SLICE]   = s_s;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                w_q  <= '0;
                cy_q <= 1'b0;
            end else if (adv) begin
                w_q  <= w_d;
                cy_q <= co;
            end
        end

        // Pending b' slices shrink by one slice per level.
        if (BW > SLICE) begin : g_b
            logic [BW-SLICE-1:0] b_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)   b_q <= '0;
                else if (adv) b_q <= bw[BW-1:SLICE];
            end
        end
    end

    assign out_valid = vld_q[STAGES];
    assign sum       = g_lvl[STAGES-1].w_q;
    assign cout      = g_lvl[STAGES-1].cy_q;
endmodule

// File: tb/tb_pipe_csa_adder.sv
// Self-checking bench for pipe_csa_adder (WIDTH=256, SLICE=64); honours PIPE_CSA_SUB_EN.
module tb_pipe_csa_adder;
    localparam int W   = 256;
    localparam int S   = 64;
    localparam int STG = W / S;
`ifdef PIPE_CSA_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0] a, b, sum;
    logic         cin, sub, cout;

    int errors = 0;
    int checks = 0;
    logic [W:0] exp_q[$];

    always #5 clk = ~clk;

    pipe_csa_adder #(.WIDTH(W), .SLICE(S)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout)
    );

    // Reference: plain (WIDTH+1)-bit arithmetic.
    function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic ci, input logic s);
        if (SUB_EN && s) return {1'b1, x} - {1'b0, y};
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    endfunction

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] r;
        for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    task automatic do_reset();
        in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_reset();
        in_valid = 1'b0; out_ready = 1'b0; a = '1; b = '1; cin = 1'b1; sub = 1'b0;
        rst_n = 1'b0;
        @(negedge clk); @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (sum !== '0 || cout !== 1'b0) begin errors++; $display("FAIL reset_data: got cout=%b sum=%h want 0", cout, sum); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_latency();
        int lat = -1;
        int vcnt = 0;
        do_reset();
        a = '1; b = '0; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL latency_in_ready: got %b want 1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            #1;
            if (out_valid === 1'b1) begin
                if (lat < 0) begin
                    lat = c;
                    checks++;
                    if (sum !== '0 || cout !== 1'b1) begin
                        errors++; $display("FAIL latency_result: got cout=%b sum=%h want cout=1 sum=0", cout, sum);
                    end
                end
                vcnt++;
            end
            @(negedge clk);
        end
        checks++; if (lat != STG) begin errors++; $display("FAIL latency_cycles: got %0d want %0d", lat, STG); end
        checks++; if (vcnt != 1) begin errors++; $display("FAIL latency_valid_count: got %0d want 1", vcnt); end
    endtask

    task automatic test_back_to_back();
        int got = 0;
        logic [W-1:0] e;
        do_reset();
        for (int c = 0; c < 20; c++) begin
            in_valid = (c < 8); a = 654251211; b = 5151511 + c; cin = 1'b0; sub = 1'b0;
            #1;
            if (out_valid === 1'b1) begin
                e = 659402722 + got;
                checks++;
                if (c != STG + got) begin errors++; $display("FAIL b2b_timing: result %0d at cycle %0d want %0d", got, c, STG + got); end
                checks++;
                if (sum !== e || cout !== 1'b0) begin errors++; $display("FAIL b2b_value: got cout=%b sum=%0d want cout=0 sum=%0d", cout, sum, e); end
                got++;
            end
            @(negedge clk);
        end
        checks++; if (got != 8) begin errors++; $display("FAIL b2b_count: got %0d want 8", got); end
    endtask

    task automatic test_stall();
        logic [W:0]   ex[2];
        logic [W-1:0] xa[2], xb[2];
        logic         xc[2];
        logic [W-1:0] hs;
        logic         hc;
        int got = 0;
        int nstall = 0;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            xa[i] = rand_word(); xb[i] = rand_word(); xc[i] = 1'($urandom_range(0, 1));
            ex[i] = ref_add(xa[i], xb[i], xc[i], 1'b0);
        end
        hs = '0; hc = 1'b0;
        for (int c = 0; c < 20; c++) begin
            in_valid = (c < 2); a = xa[c % 2]; b = xb[c % 2]; cin = xc[c % 2]; sub = 1'b0;
            out_ready = !(c >= 2 && c < 7);
            #1;
            if (out_valid === 1'b1 && out_ready === 1'b0) begin
                nstall++;
                checks++;
                if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: got %b want 0 at cycle %0d", in_ready, c); end
                if (nstall == 1) begin
                    hs = sum; hc = cout;
                end else begin
                    checks++;
                    if (sum !== hs || cout !== hc) begin errors++; $display("FAIL stall_hold: got cout=%b sum=%h want cout=%b sum=%h", cout, sum, hc, hs); end
                end
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                checks++;
                if (got > 1) begin
                    errors++; $display("FAIL stall_dup: extra result %0d", got);
                end else if ({cout, sum} !== ex[got]) begin
                    errors++; $display("FAIL stall_value: got %h want %h", {cout, sum}, ex[got]);
                end
                got++;
            end
            @(negedge clk);
        end
        checks++; if (nstall != 3) begin errors++; $display("FAIL stall_cycles: got %0d want 3", nstall); end
        checks++; if (got != 2) begin errors++; $display("FAIL stall_count: got %0d want 2", got); end
    endtask

    task automatic test_sub();
        logic [W:0]   ex[2];
        logic [W-1:0] m25;
        int got = 0;
        m25 = '0; m25 = m25 - 25;
        if (SUB_EN) begin
            ex[0] = {1'b1, 256'd25}; ex[1] = {1'b0, m25};
        end else begin
            ex[0] = {1'b0, 256'd175}; ex[1] = {1'b0, 256'd175};
        end
        do_reset();
        for (int c = 0; c < 12; c++) begin
            in_valid = (c < 2); sub = 1'b1; cin = 1'b0;
            a = (c == 0) ? 256'd100 : 256'd75;
            b = (c == 0) ? 256'd75 : 256'd100;
            #1;
            if (out_valid === 1'b1) begin
                checks++;
                if (got > 1) begin
                    errors++; $display("FAIL sub_dup: extra result %0d", got);
                end else if ({cout, sum} !== ex[got]) begin
                    errors++; $display("FAIL sub_value%0d: got %h want %h", got, {cout, sum}, ex[got]);
                end
                got++;
            end
            @(negedge clk);
        end
        checks++; if (got != 2) begin errors++; $display("FAIL sub_count: got %0d want 2", got); end
    endtask

    task automatic test_reset_midflight();
        int stale = 0;
        do_reset();
        for (int c = 0; c < STG; c++) begin
            in_valid = (c < 3); a = rand_word(); b = rand_word(); cin = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        in_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL midrst_inflight: got out_valid=%b want 1", out_valid); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_async_valid: got %b want 0", out_valid); end
        checks++; if (sum !== '0 || cout !== 1'b0) begin errors++; $display("FAIL midrst_async_data: got cout=%b sum=%h want 0", cout, sum); end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready: got %b want 1", in_ready); end
        for (int c = 0; c < 12; c++) begin
            #1;
            if (out_valid !== 1'b0) stale++;
            @(negedge clk);
        end
        checks++; if (stale != 0) begin errors++; $display("FAIL midrst_stale: got %0d valid cycles want 0", stale); end
    endtask

    task automatic test_random();
        logic [W:0]   e;
        logic [W-1:0] psum;
        logic         pcout, pstall;
        do_reset();
        exp_q.delete();
        pstall = 1'b0; psum = '0; pcout = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            a = rand_word(); b = rand_word();
            if ($urandom_range(0, 3) == 0) a = '1;
            if ($urandom_range(0, 3) == 0) b = {{(W-32){1'b0}}, 32'($urandom())};
            if ($urandom_range(0, 7) == 0) b = a;
            cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
            #1;
            checks++;
            if (in_ready !== (!out_valid || out_ready)) begin errors++; $display("FAIL rand_in_ready: got %b at cycle %0d", in_ready, c); end
            if (pstall) begin
                checks++;
                if (out_valid !== 1'b1 || sum !== psum || cout !== pcout) begin
                    errors++; $display("FAIL rand_hold: cycle %0d got v=%b cout=%b sum=%h want v=1 cout=%b sum=%h", c, out_valid, cout, sum, pcout, psum);
                end
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL rand_extra: unexpected result %h at cycle %0d", {cout, sum}, c);
                end else begin
                    e = exp_q.pop_front();
                    if ({cout, sum} !== e) begin errors++; $display("FAIL rand_value: cycle %0d got %h want %h", c, {cout, sum}, e); end
                end
            end
            if (in_valid && in_ready === 1'b1) exp_q.push_back(ref_add(a, b, cin, sub));
            pstall = (out_valid === 1'b1) && !out_ready;
            psum = sum; pcout = cout;
            @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < STG + 4; c++) begin
            #1;
            if (out_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL rand_drain_extra: unexpected result %h", {cout, sum});
                end else begin
                    e = exp_q.pop_front();
                    if ({cout, sum} !== e) begin errors++; $display("FAIL rand_drain_value: got %h want %h", {cout, sum}, e); end
                end
            end
            @(negedge clk);
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rand_drops: %0d results never emitted", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_back_to_back();
        test_stall();
        test_sub();
        test_reset_midflight();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
